// File: rtl/polyphase_path2_combine_teg_if.sv
// rtl/polyphase_path2_combine_teg_if.sv - pair-in / full-rate-out bundle for the path-2 recombiner
interface polyphase_path2_combine_teg_if #(
    parameter int BW = 6
);
    logic [BW-1:0] in1;
    logic [BW-1:0] in2;
    logic          vld;
    logic          clr;
    logic [BW-1:0] out;
    logic          ovld;
    logic          unf;
    logic          ovf;

    modport master (
        output in1, in2, vld, clr,
        input  out, ovld, unf, ovf
    );

    modport slave (
        input  in1, in2, vld, clr,
        output out, ovld, unf, ovf
    );
endinterface

// File: rtl/polyphase_path2_combine_teg.sv
// rtl/polyphase_path2_combine_teg.sv - two-path polyphase 2:1 interpolating commutator
module polyphase_path2_combine_teg #(
    parameter int BW = 6
) (
    input  logic                         clk_i,
    input  logic                         res_i,
    polyphase_path2_combine_teg_if.slave bus
);
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_e;

    phase_e        state_q, state_d;
    logic [BW-1:0] out_q, out_d;
    logic          ovld_q, ovld_d;
    logic [BW-1:0] hold_q, hold_d;
    logic [BW-1:0] s1_q, s1_d;
    logic [BW-1:0] s2_q, s2_d;
    logic          pend_q, pend_d;
    logic          act_q, act_d;
    logic          unf_q, unf_d;
    logic          ovf_q, ovf_d;
    logic          unf_set, ovf_set;

    always_ff @(posedge clk_i) begin
        if (!res_i) begin
            state_q <= EVEN;
            out_q   <= '0;
            ovld_q  <= 1'b0;
            hold_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            pend_q  <= 1'b0;
            act_q   <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ovld_q  <= ovld_d;
            hold_q  <= hold_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    // EVEN leaves only when a pair (staged or arriving) is available to emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EVEN:    state_d = (pend_q || bus.vld) ? ODD : EVEN;
            ODD:     state_d = EVEN;
            default: state_d = EVEN;
        endcase
    end

    always_comb begin
        out_d   = '0;
        ovld_d  = 1'b0;
        hold_d  = hold_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        pend_d  = pend_q;
        act_d   = act_q;
        unf_set = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            EVEN: begin
                if (pend_q) begin
                    out_d  = s2_q;
                    ovld_d = 1'b1;
                    hold_d = s1_q;
                    act_d  = 1'b1;
                    // Staging is freed this edge, so a new pair refills it directly.
                    if (bus.vld) begin
                        s1_d = bus.in1;
                        s2_d = bus.in2;
                    end else begin
                        pend_d = 1'b0;
                    end
                end else if (bus.vld) begin
                    out_d  = bus.in2;
                    ovld_d = 1'b1;
                    hold_d = bus.in1;
                    act_d  = 1'b1;
                end else if (act_q) begin
                    unf_set = 1'b1;
                    act_d   = 1'b0;
                end
            end
            ODD: begin
                out_d  = hold_q;
                ovld_d = 1'b1;
                if (bus.vld) begin
                    if (!pend_q) begin
                        s1_d   = bus.in1;
                        s2_d   = bus.in2;
                        pend_d = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        unf_d = unf_set | (unf_q & ~bus.clr);
        ovf_d = ovf_set | (ovf_q & ~bus.clr);
    end

    assign bus.out  = out_q;
    assign bus.ovld = ovld_q;
    assign bus.unf  = unf_q;
    assign bus.ovf  = ovf_q;
endmodule
